// File: rtl/dmem_block_mover.sv
// Byte-wide data-memory initiator: overlap-safe block copy (memmove) or block
// fill on a single start pulse, one memory access per cycle, registered bus.
module dmem_block_mover #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] length,
  input  logic [7:0]    fill_value,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FILL = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  state_e        state_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] count_q;
  logic [7:0]    fill_q;
  logic          backward_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_read_q;
  logic          mem_write_q;
  logic [7:0]    mem_wdata_q;
  logic          busy_q;
  logic          done_q;

  logic [AW-1:0] delta_s;
  logic          back_start_s;
  logic [AW-1:0] idx_init_s;
  logic [AW-1:0] idx_d;
  logic [AW-1:0] count_d;
  logic          last_s;

  // Direction decision at start, and next index/count during the transfer
  always_comb begin
    delta_s      = dst_addr - src_addr;
    back_start_s = !mode && (delta_s != {AW{1'b0}}) && (delta_s < length);
    idx_init_s   = back_start_s ? (length - AW'(1)) : {AW{1'b0}};
    idx_d        = backward_q ? (idx_q - AW'(1)) : (idx_q + AW'(1));
    count_d      = count_q + AW'(1);
    last_s       = (count_d == len_q);
  end

  // Transfer FSM; bus outputs are loaded for the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      src_q       <= {AW{1'b0}};
      dst_q       <= {AW{1'b0}};
      len_q       <= {AW{1'b0}};
      idx_q       <= {AW{1'b0}};
      count_q     <= {AW{1'b0}};
      fill_q      <= 8'h00;
      backward_q  <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          mem_addr_q  <= {AW{1'b0}};
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          mem_wdata_q <= 8'h00;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          if (start) begin
            src_q      <= src_addr;
            dst_q      <= dst_addr;
            len_q      <= length;
            fill_q     <= fill_value;
            backward_q <= back_start_s;
            idx_q      <= idx_init_s;
            count_q    <= {AW{1'b0}};
            if (length == {AW{1'b0}}) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else if (mode) begin
              state_q     <= S_FILL;
              busy_q      <= 1'b1;
              mem_write_q <= 1'b1;
              mem_addr_q  <= dst_addr + idx_init_s;
              mem_wdata_q <= fill_value;
            end else begin
              state_q    <= S_RD;
              busy_q     <= 1'b1;
              mem_read_q <= 1'b1;
              mem_addr_q <= src_addr + idx_init_s;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RD: begin
          // mem_wdata_q doubles as the holding register for the byte read
          state_q     <= S_WR;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b1;
          mem_addr_q  <= dst_q + idx_q;
          mem_wdata_q <= mem_rdata;
          busy_q      <= 1'b1;
          done_q      <= 1'b0;
        end
        S_WR: begin
          count_q     <= count_d;
          mem_write_q <= 1'b0;
          mem_wdata_q <= 8'h00;
          if (last_s) begin
            state_q    <= S_FIN;
            mem_read_q <= 1'b0;
            mem_addr_q <= {AW{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            state_q    <= S_RD;
            idx_q      <= idx_d;
            mem_read_q <= 1'b1;
            mem_addr_q <= src_q + idx_d;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        S_FILL: begin
          count_q    <= count_d;
          mem_read_q <= 1'b0;
          if (last_s) begin
            state_q     <= S_FIN;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            state_q     <= S_FILL;
            idx_q       <= idx_d;
            mem_write_q <= 1'b1;
            mem_addr_q  <= dst_q + idx_d;
            mem_wdata_q <= fill_q;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        S_FIN: begin
          state_q     <= S_IDLE;
          mem_addr_q  <= {AW{1'b0}};
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          mem_wdata_q <= 8'h00;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          mem_addr_q  <= {AW{1'b0}};
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          mem_wdata_q <= 8'h00;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule

// File: tb/tb_dmem_block_mover.sv
// Bench for dmem_block_mover: table vectors, random ops against a memmove/fill
// model with an expected access trace, plus start-while-busy and reset abort.
module tb_dmem_block_mover;
  localparam int AW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] src_addr = 8'h00;
  logic [7:0] dst_addr = 8'h00;
  logic [7:0] length = 8'h00;
  logic [7:0] fill_value = 8'h00;
  logic [7:0] mem_addr;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic [7:0] count;

  logic [7:0] mem [256];
  logic [7:0] seed [256];
  logic [7:0] ref_mem [256];
  logic       load = 1'b0;

  int errors = 0;
  int checks = 0;

  bit         eq_w [$];
  logic [7:0] eq_a [$];
  logic [7:0] eq_d [$];

  dmem_block_mover #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 256; k++) mem[k] <= seed[k];
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_mem();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  // memmove/fill model: expected access trace and final memory image
  task automatic model_op(input bit md, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] fv);
    logic [7:0] orig [256];
    bit back;
    int i;
    for (int k = 0; k < 256; k++) begin orig[k] = mem[k]; ref_mem[k] = mem[k]; end
    eq_w.delete(); eq_a.delete(); eq_d.delete();
    back = 1'b0;
    if (!md) for (int k = 1; k < int'(l); k++) if (8'(s + k) == d) back = 1'b1;
    for (int n = 0; n < int'(l); n++) begin
      i = back ? int'(l) - 1 - n : n;
      if (md) begin
        eq_w.push_back(1'b1); eq_a.push_back(8'(d + i)); eq_d.push_back(fv);
        ref_mem[8'(d + i)] = fv;
      end else begin
        eq_w.push_back(1'b0); eq_a.push_back(8'(s + i)); eq_d.push_back(8'h00);
        eq_w.push_back(1'b1); eq_a.push_back(8'(d + i)); eq_d.push_back(orig[8'(s + i)]);
        ref_mem[8'(d + i)] = orig[8'(s + i)];
      end
    end
  endtask

  task automatic run_op(input bit md, input logic [7:0] s, input logic [7:0] d,
                        input logic [7:0] l, input logic [7:0] fv, input int inj,
                        output int first_a, output int done_cyc);
    int busy_n, exp_done, ndone, nbad;
    bit w; logic [7:0] a, dd;
    model_op(md, s, d, l, fv);
    busy_n   = (l == 8'h00) ? 0 : (md ? int'(l) : 2 * int'(l));
    exp_done = busy_n + 1;
    first_a  = -1; done_cyc = -1; ndone = 0;
    @(negedge clk);
    mode = md; src_addr = s; dst_addr = d; length = l; fill_value = fv; start = 1'b1;
    for (int cyc = 1; cyc <= exp_done + 2; cyc++) begin
      @(negedge clk);
      chk("rw_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
      if (!mem_read && !mem_write) begin
        chk("idle_bus_zero", {16'd0, mem_addr, mem_wdata}, 32'd0);
      end else begin
        if (first_a < 0) first_a = int'(mem_addr);
        if (eq_a.size() == 0) begin
          chk("extra_access", 32'd1, 32'd0);
        end else begin
          w = eq_w.pop_front(); a = eq_a.pop_front(); dd = eq_d.pop_front();
          chk("access_kind", {31'd0, mem_write}, {31'd0, w});
          chk("access_addr", {24'd0, mem_addr}, {24'd0, a});
          if (w) chk("access_wdata", {24'd0, mem_wdata}, {24'd0, dd});
        end
      end
      chk("busy", {31'd0, busy}, {31'd0, cyc <= busy_n});
      chk("done", {31'd0, done}, {31'd0, cyc == exp_done});
      if (done) begin ndone++; done_cyc = cyc; end
      start = (cyc == inj);
      if (cyc == inj) begin dst_addr = d + 8'h33; src_addr = s + 8'h05; length = l + 8'h02; end
    end
    start = 1'b0;
    chk("missing_access", eq_a.size(), 32'd0);
    chk("done_pulses", ndone, 32'd1);
    chk("count_final", {24'd0, count}, {24'd0, l});
    nbad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) nbad++;
    chk("mem_image", nbad, 32'd0);
  endtask

  typedef struct {
    bit         md;
    logic [7:0] s, d, l, fv;
    int         exp_first;
    int         exp_done;
  } vec_t;

  vec_t vt [8];
  int fa, dc;
  logic [7:0] rs, rd, rl;

  initial begin
    vt[0] = '{1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 32'h10, 9};
    vt[1] = '{1'b0, 8'h20, 8'h22, 8'd4, 8'h00, 32'h23, 9};
    vt[2] = '{1'b1, 8'h00, 8'hFE, 8'd3, 8'hA5, 32'hFE, 4};
    vt[3] = '{1'b0, 8'h10, 8'h50, 8'd0, 8'h00, -1,     1};
    vt[4] = '{1'b0, 8'h30, 8'h30, 8'd3, 8'h00, 32'h30, 7};
    vt[5] = '{1'b0, 8'hFE, 8'h00, 8'd4, 8'h00, 32'h01, 9};
    vt[6] = '{1'b1, 8'h00, 8'h80, 8'd1, 8'h3C, 32'h80, 2};
    vt[7] = '{1'b0, 8'h52, 8'h50, 8'd5, 8'h00, 32'h52, 11};

    for (int k = 0; k < 256; k++) seed[k] = 8'($urandom);
    seed[8'h10] = 8'h11; seed[8'h11] = 8'h22; seed[8'h12] = 8'h33; seed[8'h13] = 8'h44;
    seed[8'h20] = 8'h01; seed[8'h21] = 8'h02; seed[8'h22] = 8'h03; seed[8'h23] = 8'h04;
    load_mem();
    chk("reset_outputs", {4'd0, mem_addr, mem_read, mem_write, mem_wdata, busy, done, count}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      run_op(vt[v].md, vt[v].s, vt[v].d, vt[v].l, vt[v].fv, 0, fa, dc);
      chk($sformatf("vec%0d_first_addr", v), fa, vt[v].exp_first);
      chk($sformatf("vec%0d_done_cycle", v), dc, vt[v].exp_done);
    end
    chk("fwd_copy_m40", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'h11223344);
    chk("overlap_m20", {16'd0, mem[8'h20], mem[8'h21]}, 32'h0102);
    chk("overlap_m22", {mem[8'h22], mem[8'h23], mem[8'h24], mem[8'h25]}, 32'h01020304);
    chk("fill_wrap", {8'd0, mem[8'hFE], mem[8'hFF], mem[8'h00]}, 32'h00A5A5A5);

    // second start mid-copy must be ignored
    run_op(1'b0, 8'h70, 8'h90, 8'd6, 8'h00, 3, fa, dc);
    chk("busy_start_done_cycle", dc, 32'd13);

    for (int r = 0; r < 25; r++) begin
      rs = 8'($urandom);
      rd = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'(rs + $urandom_range(0, 24) - 12);
      rl = 8'($urandom_range(0, 20));
      run_op(1'($urandom), rs, rd, rl, 8'($urandom), 0, fa, dc);
    end

    // reset during the write of byte 2 of a 4-byte copy
    for (int k = 0; k < 256; k++) seed[k] = 8'h00;
    seed[8'h10] = 8'h11; seed[8'h11] = 8'h22; seed[8'h12] = 8'h33; seed[8'h13] = 8'h44;
    load_mem();
    @(negedge clk);
    mode = 1'b0; src_addr = 8'h10; dst_addr = 8'h60; length = 8'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_wr_b2_active", {31'd0, mem_write}, 32'd1);
    chk("rst_wr_b2_addr", {24'd0, mem_addr}, 32'h62);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_write_drop", {31'd0, mem_write}, 32'd0);
    chk("rst_outputs", {4'd0, mem_addr, mem_read, mem_write, mem_wdata, busy, done, count}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_no_done", {31'd0, done}, 32'd0);
    end
    chk("rst_partial_mem", {mem[8'h60], mem[8'h61], mem[8'h62], mem[8'h63]}, 32'h11220000);
    rst_n = 1'b1;
    run_op(1'b0, 8'h10, 8'h60, 8'd4, 8'h00, 0, fa, dc);
    chk("after_rst_done_cycle", dc, 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
